// File: rtl/clk_div_ctrl_pkg.sv
// Shared types for the clock divider configuration sequencer.
package clk_div_ctrl_pkg;

  localparam int unsigned DIV_VALUE_WIDTH_DEF = 8;

  typedef logic [DIV_VALUE_WIDTH_DEF-1:0] div_value_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUIET = 2'd1,
    LOAD  = 2'd2
  } state_e;

  // Width needed to hold a count of 0..q.
  function automatic int unsigned cnt_width(input int unsigned q);
    return (q < 1) ? 1 : $clog2(q + 1);
  endfunction

endpackage

// File: rtl/clk_div_ctrl_counter.sv
// Loadable up/down counter used for the quiet-period countdown.
module clk_div_ctrl_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (clear_i) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= d_i;
    end else if (en_i) begin
      q_q <= down_i ? (q_q - WIDTH'(1)) : (q_q + WIDTH'(1));
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Gates the divider, waits a quiet period, then hands over a new divide value.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned DIV_VALUE_WIDTH   = DIV_VALUE_WIDTH_DEF,
  parameter int unsigned DEFAULT_DIV_VALUE = 1,
  parameter int unsigned QUIET_CYCLES      = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic [DIV_VALUE_WIDTH-1:0] cfg_div_i,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  output logic                       cfg_err_o,
  output logic [DIV_VALUE_WIDTH-1:0] div_o,
  output logic                       div_valid_o,
  input  logic                       div_ready_i,
  output logic                       div_en_o,
  output logic [DIV_VALUE_WIDTH-1:0] cur_div_o,
  output logic                       busy_o
);

  if (DEFAULT_DIV_VALUE == 0) begin : g_bad_default
    $error("clk_div_ctrl: DEFAULT_DIV_VALUE must be nonzero");
  end
  if (QUIET_CYCLES == 0) begin : g_bad_quiet
    $error("clk_div_ctrl: QUIET_CYCLES must be at least 1");
  end

  localparam int unsigned CNT_W = cnt_width(QUIET_CYCLES);
  localparam logic [CNT_W-1:0] QUIET_LOAD = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [DIV_VALUE_WIDTH-1:0] DEF_DIV = DIV_VALUE_WIDTH'(DEFAULT_DIV_VALUE);

  state_e                     state_q, state_d;
  logic [DIV_VALUE_WIDTH-1:0] pend_q;
  logic [DIV_VALUE_WIDTH-1:0] cur_q;
  logic                       div_en_q;
  logic                       err_q;
  logic [CNT_W-1:0]           cnt_q;

  logic req_fire;
  logic req_zero;
  logic req_same;
  logic req_change;
  logic cnt_zero;
  logic handover;

  assign req_fire   = (state_q == IDLE) && cfg_valid_i;
  assign req_zero   = (cfg_div_i == '0);
  assign req_same   = (cfg_div_i == cur_q);
  assign req_change = req_fire && !req_zero && !req_same;
  assign cnt_zero   = (cnt_q == '0);
  assign handover   = (state_q == LOAD) && div_ready_i;

  clk_div_ctrl_counter #(
    .WIDTH (CNT_W)
  ) u_quiet_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (1'b0),
    .en_i    ((state_q == QUIET) && !cnt_zero),
    .load_i  (req_change),
    .down_i  (1'b1),
    .d_i     (QUIET_LOAD),
    .q_o     (cnt_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_change) state_d = QUIET;
      QUIET:   if (cnt_zero)   state_d = LOAD;
      LOAD:    if (div_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Enable follows en_i only in an undisturbed IDLE cycle; a change request gates it at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q   <= DEF_DIV;
      cur_q    <= DEF_DIV;
      div_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      div_en_q <= ((state_q == IDLE) && !req_change) ? en_i : 1'b0;
      err_q    <= req_fire && req_zero;
      if (req_change) begin
        pend_q <= cfg_div_i;
      end
      if (handover) begin
        cur_q <= pend_q;
      end
    end
  end

  assign cfg_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign div_valid_o = (state_q == LOAD);
  assign div_o       = (state_q == LOAD) ? pend_q : cur_q;
  assign div_en_o    = div_en_q;
  assign cur_div_o   = cur_q;
  assign cfg_err_o   = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed table, stall/reset sequences, random run.
module tb_clk_div_ctrl;

  localparam int unsigned W   = 8;
  localparam int unsigned DEF = 1;
  localparam int unsigned Q   = 4;

  typedef struct packed {
    logic         ready;
    logic         valid;
    logic [W-1:0] div;
    logic         den;
    logic [W-1:0] cur;
    logic         busy;
    logic         err;
  } out_t;

  typedef struct {
    logic         en;
    logic         v;
    logic [W-1:0] d;
    logic         rdy;
    out_t         exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         en_i;
  logic [W-1:0] cfg_div_i;
  logic         cfg_valid_i;
  logic         cfg_ready_o;
  logic         cfg_err_o;
  logic [W-1:0] div_o;
  logic         div_valid_o;
  logic         div_ready_i;
  logic         div_en_o;
  logic [W-1:0] cur_div_o;
  logic         busy_o;

  int n_vec = 0;
  int n_bad = 0;
  out_t last_act;

  // Reference model: an active reconfiguration is tracked by the index of its busy cycle.
  logic [W-1:0] m_cur, m_pend;
  bit           m_active;
  int           m_t;
  logic         m_en, m_err;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .DIV_VALUE_WIDTH   (W),
    .DEFAULT_DIV_VALUE (DEF),
    .QUIET_CYCLES      (Q)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .cfg_div_i   (cfg_div_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_err_o   (cfg_err_o),
    .div_o       (div_o),
    .div_valid_o (div_valid_o),
    .div_ready_i (div_ready_i),
    .div_en_o    (div_en_o),
    .cur_div_o   (cur_div_o),
    .busy_o      (busy_o)
  );

  function automatic out_t mk(input logic r, input logic v, input int d, input logic e,
                              input int c, input logic b, input logic x);
    out_t o;
    o.ready = r; o.valid = v; o.div = W'(d); o.den = e; o.cur = W'(c); o.busy = b; o.err = x;
    return o;
  endfunction

  task automatic model_reset();
    m_cur = W'(DEF); m_pend = W'(DEF); m_active = 0; m_t = 0; m_en = 0; m_err = 0;
  endtask

  function automatic out_t model_out();
    bit in_load;
    in_load = m_active && (m_t > Q);
    return mk(!m_active, in_load, in_load ? int'(m_pend) : int'(m_cur), m_en, int'(m_cur),
              m_active, m_err);
  endfunction

  task automatic model_update(input logic en, input logic v, input logic [W-1:0] d,
                              input logic rdy);
    bit chg;
    chg   = !m_active && v && (d != 0) && (d != m_cur);
    m_err = !m_active && v && (d == 0);
    m_en  = (!m_active && !chg) ? en : 1'b0;
    if (!m_active) begin
      if (chg) begin
        m_active = 1; m_t = 1; m_pend = d;
      end
    end else if (m_t > Q) begin
      if (rdy) begin
        m_cur = m_pend; m_active = 0;
      end
    end else begin
      m_t++;
    end
  endtask

  task automatic check_out(input string name, input out_t exp);
    out_t act;
    act = {cfg_ready_o, div_valid_o, div_o, div_en_o, cur_div_o, busy_o, cfg_err_o};
    last_act = act;
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got rdy=%0b vld=%0b div=%0d en=%0b cur=%0d busy=%0b err=%0b, want rdy=%0b vld=%0b div=%0d en=%0b cur=%0d busy=%0b err=%0b",
               name, act.ready, act.valid, act.div, act.den, act.cur, act.busy, act.err,
               exp.ready, exp.valid, exp.div, exp.den, exp.cur, exp.busy, exp.err);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic v, input logic [W-1:0] d, input logic rdy,
                      input bit use_tab, input out_t tab_exp, input string name);
    en_i = en; cfg_valid_i = v; cfg_div_i = d; div_ready_i = rdy;
    @(negedge clk);
    check_out(name, use_tab ? tab_exp : model_out());
    @(posedge clk);
    model_update(en, v, d, rdy);
    #1;
  endtask

  vec_t tab [16];

  initial begin
    int n_valid;
    int r;
    logic [W-1:0] d;

    // Expected outputs below are written from the timing rules with Q=4, default value 1.
    tab[0]  = '{1, 0, 0, 1, mk(1, 0, 1, 0, 1, 0, 0)};
    tab[1]  = '{1, 0, 0, 1, mk(1, 0, 1, 1, 1, 0, 0)};
    tab[2]  = '{1, 1, 5, 1, mk(1, 0, 1, 1, 1, 0, 0)};
    tab[3]  = '{1, 0, 0, 1, mk(0, 0, 1, 0, 1, 1, 0)};
    tab[4]  = '{1, 0, 0, 1, mk(0, 0, 1, 0, 1, 1, 0)};
    tab[5]  = '{1, 0, 0, 1, mk(0, 0, 1, 0, 1, 1, 0)};
    tab[6]  = '{1, 0, 0, 1, mk(0, 0, 1, 0, 1, 1, 0)};
    tab[7]  = '{1, 0, 0, 1, mk(0, 1, 5, 0, 1, 1, 0)};
    tab[8]  = '{1, 0, 0, 1, mk(1, 0, 5, 0, 5, 0, 0)};
    tab[9]  = '{1, 0, 0, 1, mk(1, 0, 5, 1, 5, 0, 0)};
    tab[10] = '{1, 1, 0, 1, mk(1, 0, 5, 1, 5, 0, 0)};
    tab[11] = '{1, 0, 0, 1, mk(1, 0, 5, 1, 5, 0, 1)};
    tab[12] = '{1, 0, 0, 1, mk(1, 0, 5, 1, 5, 0, 0)};
    tab[13] = '{1, 1, 5, 1, mk(1, 0, 5, 1, 5, 0, 0)};
    tab[14] = '{1, 0, 0, 1, mk(1, 0, 5, 1, 5, 0, 0)};
    tab[15] = '{1, 0, 0, 1, mk(1, 0, 5, 1, 5, 0, 0)};

    rst_ni = 1'b0; en_i = 1'b1; cfg_valid_i = 1'b0; cfg_div_i = '0; div_ready_i = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_out("reset_state", mk(1, 0, DEF, 0, DEF, 0, 0));
    @(posedge clk);
    #1 rst_ni = 1'b1;

    foreach (tab[i]) begin
      step(tab[i].en, tab[i].v, tab[i].d, tab[i].rdy, 1'b1, tab[i].exp,
           $sformatf("table[%0d]", i));
    end

    // Divider holds off ready for three LOAD cycles.
    n_valid = 0;
    step(1, 1, 7, 0, 0, '0, "stall_req");
    for (int i = 0; i < Q + 3; i++) begin
      step(1, 0, 0, 0, 0, '0, $sformatf("stall_wait[%0d]", i));
      if (last_act.valid && last_act.div == 7) n_valid++;
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 1, 0, '0, $sformatf("stall_done[%0d]", i));
      if (last_act.valid && last_act.div == 7) n_valid++;
    end
    check_int("stall_valid_cycles", n_valid, 4);
    check_int("stall_cur_div", int'(cur_div_o), 7);

    // Reset arrives while the request of 9 is still in its quiet period.
    n_valid = 0;
    step(1, 1, 9, 1, 0, '0, "rst_req");
    step(1, 0, 0, 1, 0, '0, "rst_quiet0");
    step(1, 0, 0, 1, 0, '0, "rst_quiet1");
    rst_ni = 1'b0;
    #2;
    model_reset();
    check_out("rst_async", mk(1, 0, DEF, 0, DEF, 0, 0));
    @(posedge clk);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < Q + 4; i++) begin
      step(1, 0, 0, 1, 0, '0, $sformatf("rst_after[%0d]", i));
      if (last_act.valid) n_valid++;
    end
    check_int("rst_no_handover", n_valid, 0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 3);
      d = (r == 0) ? '0 : (r == 1) ? m_cur : W'($urandom_range(1, 255));
      step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 9) < 3), d,
           1'($urandom_range(0, 9) < 6), 0, '0, $sformatf("rand[%0d]", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
